// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared constants and controller state type for the register write arbiter
package reg_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a pointer that moves only on a transfer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       xfer,
  output logic [1:0] grant
);

  // prio1 set means requester 1 wins the next tie
  logic prio1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio1 <= 1'b0;
    end else if (xfer) begin
      prio1 <= grant[0];
    end
  end

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = prio1 ? 2'b10 : 2'b01;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the register file write port between two requesters and a clear sweep
module reg_write_arbiter
  import reg_pkg::ctrl_state_t;
  import reg_pkg::IDLE;
  import reg_pkg::CLEAR;
#(
  parameter int ADDR_W   = reg_pkg::ADDR_W,
  parameter int DATA_W   = reg_pkg::DATA_W,
  parameter int NUM_REGS = reg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we
);

  // One extra counter bit lets k reach NUM_REGS without wrapping to zero
  localparam logic [ADDR_W:0] K_LAST  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] K_FINAL = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] K_ONE   = (ADDR_W+1)'(1);

  ctrl_state_t       state, state_n;
  logic [ADDR_W:0]   k, k_n;
  logic [1:0]        grant;
  logic              xfer;
  logic              we_n, busy_n, done_n;
  logic [ADDR_W-1:0] wa_n;
  logic [DATA_W-1:0] wd_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .xfer   (xfer),
    .grant  (grant)
  );

  assign req0_ready = (state == IDLE) && !clear_start && grant[0];
  assign req1_ready = (state == IDLE) && !clear_start && grant[1];
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clear_start) state_n = CLEAR;
      CLEAR:   if (k == K_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered write port; wa/wd hold when nothing is written
  always_comb begin
    k_n    = '0;
    we_n   = 1'b0;
    wa_n   = wa;
    wd_n   = wd;
    busy_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          k_n    = K_ONE;
          we_n   = 1'b1;
          wa_n   = '0;
          wd_n   = '0;
          busy_n = 1'b1;
        end else if (xfer) begin
          we_n = 1'b1;
          wa_n = grant[1] ? req1_addr : req0_addr;
          wd_n = grant[1] ? req1_data : req0_data;
        end
      end
      CLEAR: begin
        if (k != K_LAST) begin
          k_n    = k + 1'b1;
          we_n   = 1'b1;
          wa_n   = k[ADDR_W-1:0];
          wd_n   = '0;
          busy_n = 1'b1;
          done_n = (k == K_FINAL);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      we         <= we_n;
      wa         <= wa_n;
      wd         <= wd_n;
      clear_busy <= busy_n;
      clear_done <= done_n;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter driving a register file model
module tb_reg_write_arbiter;

  typedef struct packed {
    logic [3:0] wa;
    logic [7:0] wd;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, clear_start;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, clear_busy, clear_done, we;
  logic [3:0] wa;
  logic [7:0] wd;
  logic [7:0] rf [16];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .wa          (wa),
    .wd          (wd),
    .we          (we)
  );

  always @(posedge clk) begin
    if (we) rf[wa] <= wd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [3:0] a, input logic [7:0] d, input logic b, input logic dn);
    exp_t e;
    e.wa = a; e.wd = d; e.busy = b; e.done = dn;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got wa=%0h wd=%0h expected no write", wa, wd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_wa", 32'(wa), 32'(e.wa));
          check("mon_wd", 32'(wd), 32'(e.wd));
          check("mon_busy", 32'(clear_busy), 32'(e.busy));
          check("mon_done", 32'(clear_done), 32'(e.done));
        end
      end else begin
        check("mon_idle_flags", 32'({clear_busy, clear_done}), 32'(0));
      end
    end
  end

  task automatic fill(input logic [7:0] base, input logic inc);
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1'b1;
      req0_addr  = 4'(i);
      req0_data  = inc ? base + 8'(i) : base;
      #1;
      check("fill_ready0", 32'(req0_ready), 32'(1));
      expect_write(4'(i), req0_data, 1'b0, 1'b0);
      tick();
    end
    req0_valid = 1'b0;
  endtask

  // Caller raises clear_start at posedge+1; this covers the 16 sweep cycles
  task automatic sweep(input int reset_at, input int again_at);
    #1;
    check("clr_start_ready0", 32'(req0_ready), 32'(0));
    check("clr_start_ready1", 32'(req1_ready), 32'(0));
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == reset_at) begin
        check("pre_reset_wa", 32'(wa), 32'(i));
        reset       = 1'b0;
        clear_start = 1'b0;
        #1;
        check("rst_we", 32'(we), 32'(0));
        check("rst_busy", 32'(clear_busy), 32'(0));
        check("rst_wa", 32'(wa), 32'(0));
        check("rst_done", 32'(clear_done), 32'(0));
        return;
      end
      clear_start = (i == again_at);
      #1;
      check("sweep_busy", 32'(clear_busy), 32'(1));
      check("sweep_ready0", 32'(req0_ready), 32'(0));
      check("sweep_ready1", 32'(req1_ready), 32'(0));
      expect_write(4'(i), 8'h00, 1'b1, i == 15);
      tick();
    end
    clear_start = 1'b0;
    check("post_sweep_busy", 32'(clear_busy), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grant_order;
    reset       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    clear_start = 1'b0;
    req0_addr   = '0; req0_data = '0;
    req1_addr   = '0; req1_data = '0;
    repeat (3) tick();
    check("reset_we", 32'(we), 32'(0));
    check("reset_wa", 32'(wa), 32'(0));
    check("reset_wd", 32'(wd), 32'(0));
    check("reset_flags", 32'({clear_busy, clear_done}), 32'(0));
    check("reset_readies", 32'({req0_ready, req1_ready}), 32'(0));
    reset = 1'b1;

    // Single write, register 3 <= 2A
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'h2A;
    #1;
    check("t1_ready0", 32'(req0_ready), 32'(1));
    check("t1_ready1", 32'(req1_ready), 32'(0));
    expect_write(4'd3, 8'h2A, 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    check("t1_we", 32'(we), 32'(1));
    check("t1_wa", 32'(wa), 32'(3));
    check("t1_wd", 32'(wd), 32'(8'h2A));
    tick();
    check("t1_rf3", 32'(rf[3]), 32'(8'h2A));

    // Leave requester 1 as last winner so the next tie goes to requester 0
    req1_valid = 1'b1; req1_addr = 4'd5; req1_data = 8'h55;
    #1;
    check("r1_ready1", 32'(req1_ready), 32'(1));
    expect_write(4'd5, 8'h55, 1'b0, 1'b0);
    tick();

    // Both valid for 4 cycles: grants 0,1,0,1
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      grant_order = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_readies", 32'({req1_ready, req0_ready}), 32'(grant_order));
      if (i % 2 == 0) expect_write(4'd1, 8'h11, 1'b0, 1'b0);
      else            expect_write(4'd2, 8'h22, 1'b0, 1'b0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Fill with FF then sweep to zero
    fill(8'hFF, 1'b0);
    clear_start = 1'b1;
    sweep(-1, -1);
    for (int i = 0; i < 16; i++) check("clr_rf_zero", 32'(rf[i]), 32'(0));

    // Clear beats a simultaneous request; request accepted right after sweep
    clear_start = 1'b1;
    req1_valid = 1'b1; req1_addr = 4'd9; req1_data = 8'h99;
    sweep(-1, -1);
    #1;
    check("t4_ready1_after", 32'(req1_ready), 32'(1));
    expect_write(4'd9, 8'h99, 1'b0, 1'b0);
    tick();
    req1_valid = 1'b0;

    // Re-asserted clear_start mid-sweep is ignored
    req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 8'h44;
    clear_start = 1'b1;
    sweep(-1, 5);
    #1;
    check("t6_ready0_after", 32'(req0_ready), 32'(1));
    expect_write(4'd4, 8'h44, 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    repeat (3) tick();
    check("t6_no_resweep", 32'(clear_busy), 32'(0));

    // Reset mid-sweep at wa=7 leaves registers 8..15 untouched
    fill(8'h80, 1'b1);
    clear_start = 1'b1;
    sweep(7, -1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
    check("t5_busy_after", 32'(clear_busy), 32'(0));
    check("t5_we_after", 32'(we), 32'(0));
    for (int i = 8; i < 16; i++) check("t5_rf_kept", 32'(rf[i]), 32'(8'h80 + i));

    repeat (2) tick();
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
